// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the SRAM memory controller.
// Holds the FSM state enum, parameter defaults and the counter MMIO map used
// when MEM_CTRL_CYCLE_CNT_EN is defined.
package mem_ctrl_pkg;

    // Parameter defaults for mem_ctrl
    localparam int ADDR_W_DEF      = 12;
    localparam int WAIT_CYCLES_DEF = 1;

    // Width of the free-running cycle counter
    localparam int CYCLE_CNT_W = 64;

    // Counter MMIO map (byte addresses)
    localparam logic [31:0] MMIO_BASE       = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_CNT_LO_OFS = 32'h0000_0000;
    localparam logic [31:0] MMIO_CNT_HI_OFS = 32'h0000_0004;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/mem_ctrl_cycle_cnt.sv
// mem_ctrl_cycle_cnt: free-running cycle counter, cleared by reset and
// wrapping at 2^CYCLE_CNT_W. Only instantiated under MEM_CTRL_CYCLE_CNT_EN.
module mem_ctrl_cycle_cnt
    import mem_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic [CYCLE_CNT_W-1:0] count_o
);

    logic [CYCLE_CNT_W-1:0] count_q;

    // Count every clock; synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= {CYCLE_CNT_W{1'b0}};
        end else begin
            count_q <= count_q + {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges a level-held rd/wr request bus onto a single-port SRAM
// with a fixed access time of WAIT_CYCLES clocks. Every request, in range
// or not, completes with a one-cycle ready pulse WAIT_CYCLES+1 cycles after
// it is first seen. Optional build macro: MEM_CTRL_CYCLE_CNT_EN maps a
// read-only 64-bit cycle counter at MMIO_BASE (low) and MMIO_BASE+4 (high).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              merged_mem_rd_i,
    input  logic              merged_mem_wr_i,
    input  logic [31:0]       merged_mem_addr_i,
    input  logic [31:0]       merged_mem_data_i,
    output logic              merged_mem_ready_o,
    output logic [31:0]       merged_mem_data_o,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    // Access counter start value; the counter reaching 1 marks the capture edge.
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic        hit_q;

    logic        req_s;
    logic        range_s;
    logic        hit_s;
    logic [31:0] rd_word_s;

`ifdef MEM_CTRL_CYCLE_CNT_EN
    localparam logic [31:0] CNT_LO_ADDR = MMIO_BASE + MMIO_CNT_LO_OFS;
    localparam logic [31:0] CNT_HI_ADDR = MMIO_BASE + MMIO_CNT_HI_OFS;

    logic                   mmio_lo_s;
    logic                   mmio_hi_s;
    logic                   mmio_lo_q;
    logic                   mmio_hi_q;
    logic [CYCLE_CNT_W-1:0] cyc_cnt_s;

    mem_ctrl_cycle_cnt u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .count_o (cyc_cnt_s)
    );
`endif

    // Classify the incoming request address: SRAM window, counter register, or nothing.
    always_comb begin
        req_s = merged_mem_rd_i | merged_mem_wr_i;
        if ((merged_mem_addr_i >> (ADDR_W + 2)) == 32'd0) begin
            range_s = 1'b1;
        end else begin
            range_s = 1'b0;
        end
`ifdef MEM_CTRL_CYCLE_CNT_EN
        mmio_lo_s = (merged_mem_addr_i[31:2] == CNT_LO_ADDR[31:2]);
        mmio_hi_s = (merged_mem_addr_i[31:2] == CNT_HI_ADDR[31:2]);
        hit_s     = range_s & ~(mmio_lo_s | mmio_hi_s);
`else
        hit_s     = range_s;
`endif
    end

    // Select the word returned at the capture edge for the latched target.
    always_comb begin
        rd_word_s = 32'd0;
        if (hit_q) begin
            rd_word_s = sram_rdata_i;
        end
`ifdef MEM_CTRL_CYCLE_CNT_EN
        else if (mmio_lo_q) begin
            rd_word_s = cyc_cnt_s[31:0];
        end else if (mmio_hi_q) begin
            rd_word_s = cyc_cnt_s[63:32];
        end
`endif
        else begin
            rd_word_s = 32'd0;
        end
    end

    // Request FSM: latch in IDLE, enable SRAM for one cycle, wait, capture, pulse ready.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q            <= ST_IDLE;
            cnt_q              <= 4'd0;
            wr_q               <= 1'b0;
            hit_q              <= 1'b0;
            merged_mem_ready_o <= 1'b0;
            merged_mem_data_o  <= 32'd0;
            sram_en_o          <= 1'b0;
            sram_we_o          <= 1'b0;
            sram_addr_o        <= {ADDR_W{1'b0}};
            sram_wdata_o       <= 32'd0;
`ifdef MEM_CTRL_CYCLE_CNT_EN
            mmio_lo_q          <= 1'b0;
            mmio_hi_q          <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    merged_mem_ready_o <= 1'b0;
                    if (req_s) begin
                        // A simultaneous rd+wr is a write: direction comes from wr alone.
                        state_q      <= ST_ACCESS;
                        cnt_q        <= WAIT_INIT;
                        wr_q         <= merged_mem_wr_i;
                        hit_q        <= hit_s;
                        sram_en_o    <= hit_s;
                        sram_we_o    <= hit_s & merged_mem_wr_i;
                        sram_addr_o  <= merged_mem_addr_i[ADDR_W+1:2];
                        sram_wdata_o <= merged_mem_data_i;
`ifdef MEM_CTRL_CYCLE_CNT_EN
                        mmio_lo_q    <= mmio_lo_s;
                        mmio_hi_q    <= mmio_hi_s;
`endif
                    end else begin
                        sram_en_o <= 1'b0;
                        sram_we_o <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // Enables are only ever high in the first access cycle.
                    sram_en_o <= 1'b0;
                    sram_we_o <= 1'b0;
                    if (cnt_q <= 4'd1) begin
                        cnt_q              <= 4'd0;
                        state_q            <= ST_RESP;
                        merged_mem_ready_o <= 1'b1;
                        merged_mem_data_o  <= wr_q ? 32'd0 : rd_word_s;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Requester drops rd/wr on this edge, so IDLE sees a clean bus.
                    merged_mem_ready_o <= 1'b0;
                    state_q            <= ST_IDLE;
                end
                default: begin
                    state_q            <= ST_IDLE;
                    cnt_q              <= 4'd0;
                    merged_mem_ready_o <= 1'b0;
                    sram_en_o          <= 1'b0;
                    sram_we_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Two instances run side by
// side (WAIT_CYCLES=1 and WAIT_CYCLES=3), each with a simple SRAM model.
// Stimulus pushes expected responses; a monitor pops them on every ready.
`timescale 1ns/1ps
module tb_mem_ctrl;

    typedef struct {
        int          id;
        int          cyc;
        bit          chk;
        logic [31:0] data;
        bit          en;
        bit          we;
        logic [11:0] sa;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    logic        rst    [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        rdy    [2];
    logic [31:0] rdata_o[2];
    logic        en     [2];
    logic        we     [2];
    logic [11:0] saddr  [2];
    logic [31:0] swdata [2];
    logic [31:0] srdata [2];

    int          en_cnt   [2] = '{0, 0};
    bit          seen_we  [2] = '{1'b0, 1'b0};
    logic [11:0] seen_sa  [2] = '{12'd0, 12'd0};
    int          n_rdy    [2] = '{0, 0};
    logic [31:0] last_data[2] = '{32'd0, 32'd0};
    bit          prev_rdy [2] = '{1'b0, 1'b0};

    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : 3;
        logic [31:0] mem [4096];
        logic [11:0] last_a = 12'd0;

        mem_ctrl #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
            .clk_i              (clk),
            .rst_i              (rst[g]),
            .merged_mem_rd_i    (rd[g]),
            .merged_mem_wr_i    (wr[g]),
            .merged_mem_addr_i  (addr[g]),
            .merged_mem_data_i  (wdata[g]),
            .merged_mem_ready_o (rdy[g]),
            .merged_mem_data_o  (rdata_o[g]),
            .sram_en_o          (en[g]),
            .sram_we_o          (we[g]),
            .sram_addr_o        (saddr[g]),
            .sram_wdata_o       (swdata[g]),
            .sram_rdata_i       (srdata[g])
        );

        always @(posedge clk) begin
            if (en[g]) begin
                last_a <= saddr[g];
                if (we[g]) mem[saddr[g]] <= swdata[g];
            end
        end

        // Read word is visible while enabled and held afterwards until the next access.
        assign srdata[g] = en[g] ? mem[saddr[g]] : mem[last_a];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT raises ready.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst[g]) en_cnt[g] = 0;
                if (en[g]) begin
                    en_cnt[g]++;
                    seen_we[g] = we[g];
                    seen_sa[g] = saddr[g];
                end
                if (rdy[g]) begin
                    n_rdy[g]++;
                    last_data[g] = rdata_o[g];
                    chk($sformatf("d%0d_pulse_len", g), 64'(prev_rdy[g]), 64'd0);
                    chk($sformatf("d%0d_ready_expected", g), 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk($sformatf("d%0d_id", g), 64'(g), 64'(e.id));
                        chk($sformatf("d%0d_latency_cycle", g), 64'(cyc), 64'(e.cyc));
                        if (e.chk) chk($sformatf("d%0d_rdata", g), 64'(rdata_o[g]), 64'(e.data));
                        chk($sformatf("d%0d_sram_en_cycles", g), 64'(en_cnt[g]), 64'(e.en));
                        if (e.en) begin
                            chk($sformatf("d%0d_sram_we", g), 64'(seen_we[g]), 64'(e.we));
                            chk($sformatf("d%0d_sram_addr", g), 64'(seen_sa[g]), 64'(e.sa));
                        end
                    end
                    en_cnt[g] = 0;
                end
                prev_rdy[g] = rdy[g];
            end
        end
    end

    task automatic do_req(input int g, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit dchk, input logic [31:0] ed,
                          input bit een, input bit ewe, input logic [11:0] esa,
                          output int issue_cyc);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        rd[g]    = r;
        wr[g]    = w;
        addr[g]  = a;
        wdata[g] = d;
        issue_cyc = cyc;
        e.id   = g;
        e.cyc  = cyc + 1 + ((g == 0) ? 1 : 3);
        e.chk  = dchk;
        e.data = ed;
        e.en   = een;
        e.we   = ewe;
        e.sa   = esa;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rdy[g]) got = 1'b1;
        end
        chk($sformatf("d%0d_ready_seen", g), 64'(got), 64'd1);
        if (!got) sb.delete();
        @(posedge clk);
        #1;
        rd[g] = 1'b0;
        wr[g] = 1'b0;
    endtask

    initial begin : stim
        int          c0;
        int          c1;
        int          nr;
        logic [31:0] v1;
        logic [31:0] v2;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b0; rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = 32'd0; wdata[g] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("d%0d_rst_ready", g), 64'(rdy[g]), 64'd0);
            chk($sformatf("d%0d_rst_data", g), 64'(rdata_o[g]), 64'd0);
            chk($sformatf("d%0d_rst_en", g), 64'(en[g]), 64'd0);
            chk($sformatf("d%0d_rst_we", g), 64'(we[g]), 64'd0);
            chk($sformatf("d%0d_rst_addr", g), 64'(saddr[g]), 64'd0);
            chk($sformatf("d%0d_rst_wdata", g), 64'(swdata[g]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // WAIT_CYCLES=1 instance
        do_req(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b1, 1'b1, 12'h004, c0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'h004, c0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0013, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'h004, c0);
        do_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1'b1, 12'h008, c0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 12'h008, c0);
        do_req(0, 1'b1, 1'b0, 32'h0001_0000, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c0);
        do_req(0, 1'b0, 1'b1, 32'h0001_0020, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 12'h008, c0);

        // WAIT_CYCLES=3 instance
        do_req(1, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 32'd0, 1'b1, 1'b1, 12'h3FF, c0);
        do_req(1, 1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 12'h3FF, c0);
        do_req(1, 1'b1, 1'b0, 32'h0000_4000, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c0);

        // Reset during the first access cycle aborts the read without a ready pulse.
        nr = n_rdy[0];
        @(posedge clk);
        #1;
        rd[0]   = 1'b1;
        addr[0] = 32'h0000_0010;
        @(posedge clk);
        #1;
        chk("abort_first_access_en", 64'(en[0]), 64'd1);
        rst[0] = 1'b0;
        rd[0]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", 64'(rdy[0]), 64'd0);
        chk("abort_data", 64'(rdata_o[0]), 64'd0);
        chk("abort_en", 64'(en[0]), 64'd0);
        chk("abort_we", 64'(we[0]), 64'd0);
        chk("abort_addr", 64'(saddr[0]), 64'd0);
        chk("abort_wdata", 64'(swdata[0]), 64'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_ready_pulse", 64'(n_rdy[0]), 64'(nr));
        do_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'h004, c0);

`ifdef MEM_CTRL_CYCLE_CNT_EN
        do_req(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 12'h000, c0);
        v1 = last_data[0];
        repeat ((c0 + 9) - cyc) @(posedge clk);
        do_req(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 12'h000, c1);
        v2 = last_data[0];
        chk("cnt_issue_gap", 64'(c1 - c0), 64'd10);
        chk("cnt_delta_10", 64'(v2 - v1), 64'd10);
        do_req(0, 1'b0, 1'b1, 32'hFFFF_0004, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c1);
        do_req(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c1);
        repeat ((c0 + 29) - cyc) @(posedge clk);
        do_req(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 12'h000, c1);
        chk("cnt_delta_30", 64'(last_data[0] - v1), 64'd30);
`else
        do_req(0, 1'b1, 1'b0, 32'hFFFF_0000, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c0);
        do_req(0, 1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_0055, 1'b1, 32'd0, 1'b0, 1'b0, 12'h000, c0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 12'h008, c0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
